// File: rtl/fifo_wr_arb_if.sv
// Write-side arbitration bus between the requesters, the arbiter and the FIFO.
interface fifo_wr_arb_if #(
   parameter int DSIZE = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*DSIZE-1:0] wdata_in;
   logic                  wfull;
   logic [NREQ-1:0]       gnt;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  busy;

   modport master (
      output req, wdata_in, wfull,
      input  gnt, winc, wdata, busy
   );

   modport slave (
      input  req, wdata_in, wfull,
      output gnt, winc, wdata, busy
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter in front of a FIFO write port.
//
// state | meaning
// IDLE  | no owner; picks the next requester after last, gnt = 0
// BURST | owner holds the FIFO write port for up to MAX_BURST words
module fifo_wr_arb #(
   parameter int DSIZE     = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4
) (
   input  logic          wclk,
   input  logic          wrst,
   fifo_wr_arb_if.slave  bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state, nxt_state;
   logic [NREQ-1:0] gnt_q, nxt_gnt;
   logic [IW-1:0]   owner, nxt_owner;
   logic [IW-1:0]   last, nxt_last;
   logic [CW-1:0]   cnt, nxt_cnt;
   logic [IW-1:0]   pick, idx;
   logic            found;
   logic            busy;
   logic            req_own;
   logic            winc;

   assign busy     = (state == BURST);
   assign req_own  = bus.req[owner];
   // Reset gates the write strobe combinationally so an interrupted burst never writes.
   assign winc     = busy & req_own & ~bus.wfull & ~wrst;
   assign bus.winc = winc;
   assign bus.busy = busy;
   assign bus.gnt  = gnt_q;
   assign bus.wdata = busy ? bus.wdata_in[owner*DSIZE +: DSIZE] : '0;

   // Round-robin search: first set req bit starting just above the previous owner.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Next-state logic: grant from IDLE, count and terminate bursts in BURST.
   always_comb begin
      nxt_state = state;
      nxt_gnt   = gnt_q;
      nxt_owner = owner;
      nxt_last  = last;
      nxt_cnt   = cnt;
      case (state)
         IDLE: begin
            nxt_gnt = '0;
            if (found) begin
               nxt_state = BURST;
               nxt_gnt   = NREQ'(1) << pick;
               nxt_owner = pick;
               nxt_cnt   = '0;
            end
         end
         BURST: begin
            if (winc) begin
               nxt_cnt = cnt + CW'(1);
            end
            if ((winc && cnt == CW'(MAX_BURST - 1)) || !req_own) begin
               nxt_state = IDLE;
               nxt_gnt   = '0;
               nxt_last  = owner;
               nxt_cnt   = '0;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_gnt   = '0;
            nxt_cnt   = '0;
         end
      endcase
   end

   // State register; reset leaves requester 0 with first priority.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state <= IDLE;
         gnt_q <= '0;
         owner <= '0;
         last  <= IW'(NREQ - 1);
         cnt   <= '0;
      end else begin
         state <= nxt_state;
         gnt_q <= nxt_gnt;
         owner <= nxt_owner;
         last  <= nxt_last;
         cnt   <= nxt_cnt;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fifo_wr_arb;
   localparam int DSIZE     = 8;
   localparam int NREQ      = 4;
   localparam int MAX_BURST = 4;
   localparam int BIG       = 1000000;

   logic wclk = 1'b0;
   logic wrst = 1'b1;

   fifo_wr_arb_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

   fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus.slave)
   );

   always #5 wclk = ~wclk;

   int n_vec = 0;
   int n_bad = 0;

   // Requesters: words still to send and a sequence number stamped into their data.
   int pend[NREQ];
   int seq[NREQ];

   // Reference model: current owner (-1 = none), words in this burst, previous owner.
   int m_owner = -1;
   int m_words = 0;
   int m_last  = NREQ - 1;
   int glog[$];
   int blog[$];

   int              obs_cnt = 0;
   int              wait_g[NREQ];
   logic [NREQ-1:0] prev_gnt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DSIZE-1:0] lane_val(input int i);
      return DSIZE'((i << 6) | (seq[i] & 63));
   endfunction

   task automatic cycle(input bit rst_v, input bit full_v);
      logic [NREQ-1:0]       r;
      logic [NREQ*DSIZE-1:0] d;
      logic [NREQ-1:0]       e_gnt;
      logic [DSIZE-1:0]      e_wd;
      bit                    e_busy, e_winc;
      int                    j;
      r = '0;
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
         r[i] = (pend[i] > 0);
         d[i*DSIZE +: DSIZE] = lane_val(i);
      end
      wrst         = rst_v;
      bus.wfull    = full_v;
      bus.req      = r;
      bus.wdata_in = d;
      @(negedge wclk);

      e_busy = (m_owner >= 0);
      e_gnt  = '0;
      e_wd   = '0;
      e_winc = 1'b0;
      if (e_busy) begin
         e_gnt  = NREQ'(1) << m_owner;
         e_wd   = d[m_owner*DSIZE +: DSIZE];
         e_winc = r[m_owner] && !full_v && !rst_v;
      end
      chk("gnt",   32'(bus.gnt),   32'(e_gnt));
      chk("busy",  32'(bus.busy),  32'(e_busy));
      chk("winc",  32'(bus.winc),  32'(e_winc));
      chk("wdata", 32'(bus.wdata), 32'(e_wd));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("winc_while_full", 32'(bus.winc & bus.wfull), 32'd0);
      chk("winc_without_gnt", 32'(bus.winc && (bus.gnt == '0)), 32'd0);

      // Observed-behaviour properties: burst length and starvation bound.
      if (rst_v) begin
         for (int i = 0; i < NREQ; i++) wait_g[i] = 0;
      end else if (bus.gnt != '0 && prev_gnt == '0) begin
         obs_cnt = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) wait_g[i] = 0;
            else if (r[i]) begin
               wait_g[i]++;
               chk("starvation", 32'(wait_g[i] < NREQ), 32'd1);
            end
         end
      end
      for (int i = 0; i < NREQ; i++) if (!r[i]) wait_g[i] = 0;
      if (bus.winc) begin
         obs_cnt++;
         chk("burst_len", 32'(obs_cnt <= MAX_BURST), 32'd1);
      end
      prev_gnt = bus.gnt;

      if (e_winc) begin
         seq[m_owner]++;
         pend[m_owner]--;
         m_words++;
      end
      if (rst_v) begin
         m_owner = -1;
         m_words = 0;
         m_last  = NREQ - 1;
      end else if (e_busy) begin
         if ((e_winc && m_words == MAX_BURST) || !r[m_owner]) begin
            blog.push_back(m_words);
            m_last  = m_owner;
            m_owner = -1;
            m_words = 0;
         end
      end else if (r != '0) begin
         for (int k = 1; k <= NREQ; k++) begin
            j = (m_last + k) % NREQ;
            if (m_owner < 0 && r[j]) m_owner = j;
         end
         m_words = 0;
         glog.push_back(m_owner);
      end
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      glog.delete();
      blog.delete();
   endtask

   task automatic run_until_bursts(input int n, input int max_cyc);
      for (int c = 0; c < max_cyc && blog.size() < n; c++) cycle(1'b0, 1'b0);
   endtask

   task automatic run_until_words(input int n, input int max_cyc);
      for (int c = 0; c < max_cyc && m_words < n; c++) cycle(1'b0, 1'b0);
   endtask

   initial begin
      int exp_order[5];
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) begin
         pend[i]   = 0;
         seq[i]    = 0;
         wait_g[i] = 0;
      end
      bus.req      = '0;
      bus.wdata_in = '0;
      bus.wfull    = 1'b0;
      @(posedge wclk);
      #1;

      // Reset state, with a request present during reset.
      pend[2] = 3;
      cycle(1'b1, 1'b0);
      pend[2] = 0;
      cycle(1'b1, 1'b0);
      chk("rst_gnt",  32'(bus.gnt),   32'd0);
      chk("rst_busy", 32'(bus.busy),  32'd0);
      chk("rst_wdata", 32'(bus.wdata), 32'd0);
      glog.delete();
      blog.delete();

      // Single requester held: back-to-back full bursts with one idle cycle between.
      do_reset();
      pend[0] = BIG;
      for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0);
      chk("s1_ngrants", 32'(glog.size() >= 2), 32'd1);
      if (glog.size() >= 2) begin
         chk("s1_grant0", 32'(glog[0]), 32'd0);
         chk("s1_grant1", 32'(glog[1]), 32'd0);
      end
      if (blog.size() >= 1) chk("s1_len", 32'(blog[0]), 32'(MAX_BURST));
      else chk("s1_bursts", 32'(blog.size()), 32'd1);

      // All requesting: round-robin order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < NREQ; i++) pend[i] = BIG;
      for (int c = 0; c < 25; c++) cycle(1'b0, 1'b0);
      chk("s2_ngrants", 32'(glog.size() >= 5), 32'd1);
      if (glog.size() >= 5) begin
         for (int g = 0; g < 5; g++) chk("s2_order", 32'(glog[g]), 32'(exp_order[g]));
      end
      if (blog.size() >= 4) begin
         for (int b = 0; b < 4; b++) chk("s2_len", 32'(blog[b]), 32'(MAX_BURST));
      end else chk("s2_bursts", 32'(blog.size()), 32'd4);

      // Requester 2 stalled by wfull after two writes for five cycles.
      do_reset();
      pend[2] = BIG;
      run_until_words(2, 10);
      chk("s3_two_writes", 32'(m_words), 32'd2);
      for (int c = 0; c < 5; c++) cycle(1'b0, 1'b1);
      run_until_bursts(1, 10);
      chk("s3_bursts", 32'(blog.size()), 32'd1);
      if (blog.size() >= 1) chk("s3_len", 32'(blog[0]), 32'(MAX_BURST));
      if (glog.size() >= 1) chk("s3_owner", 32'(glog[0]), 32'd2);

      // Requester 1 drops after one write; next grant wraps 2,3,0.
      do_reset();
      pend[1] = 1;
      run_until_bursts(1, 10);
      chk("s4_bursts", 32'(blog.size()), 32'd1);
      if (blog.size() >= 1) chk("s4_len", 32'(blog[0]), 32'd1);
      pend[0] = BIG;
      pend[1] = BIG;
      cycle(1'b0, 1'b0);
      chk("s4_ngrants", 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         chk("s4_first", 32'(glog[0]), 32'd1);
         chk("s4_next",  32'(glog[1]), 32'd0);
      end

      // Reset mid-burst after two writes, then requester 3 alone.
      do_reset();
      pend[0] = BIG;
      run_until_words(2, 10);
      chk("s5_two_writes", 32'(m_words), 32'd2);
      cycle(1'b1, 1'b0);
      pend[0] = 0;
      pend[3] = BIG;
      glog.delete();
      blog.delete();
      run_until_bursts(1, 12);
      chk("s5_bursts", 32'(blog.size()), 32'd1);
      if (glog.size() >= 1) chk("s5_owner", 32'(glog[0]), 32'd3);
      if (blog.size() >= 1) chk("s5_len", 32'(blog[0]), 32'(MAX_BURST));

      // Randomized traffic.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] <= 0 && ($urandom % 4) == 0) pend[i] = int'($urandom_range(1, 7));
         end
         cycle(($urandom % 1000) == 0, ($urandom % 4) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 8: FIFO data word width in bits.
REQ-002 Parameter NREQ, default 4: number of write requesters (2..8).
REQ-003 Parameter MAX_BURST, default 4: maximum words written per grant (1..16).
REQ-004 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-005 wrst  input  1  synchronous, active-high reset, sampled on rising wclk.
REQ-006 req  input  NREQ  per-requester write request; bit i holds while requester i has a word on its data lane.
REQ-007 wdata_in  input  NREQ*DSIZE  requester data lanes; lane i = bits [i*DSIZE +: DSIZE].
REQ-008 wfull  input  1  FIFO full flag from the write-side full logic.
REQ-009 gnt  output  NREQ  registered one-hot grant (all-zero when idle).
REQ-010 winc  output  1  FIFO write enable.
REQ-011 wdata  output  DSIZE  FIFO write data.
REQ-012 busy  output  1  high while the state machine is in BURST.

Function
REQ-013 The block SHALL implement two states, IDLE and BURST, plus a burst counter cnt and a last-owner register last.
REQ-014 In IDLE with req != 0, the block SHALL select the first set req bit searching upward from (last+1) mod NREQ and wrap around. On the next edge it SHALL load gnt with that one-hot value, set owner, clear cnt and enter BURST.
REQ-015 In IDLE with req == 0, the block SHALL keep gnt = 0 and remain in IDLE.
REQ-016 winc SHALL be combinational: winc = busy & req[owner] & !wfull & !wrst.
REQ-017 wdata SHALL be lane owner of wdata_in whenever busy, and 0 otherwise.
REQ-018 A requester's word SHALL be consumed exactly in cycles where gnt[i] & winc; the requester presents the next word, or drops req, on the following cycle.
REQ-019 cnt SHALL increment by 1 on each winc and be held otherwise; width is ceil(log2(MAX_BURST+1)).
REQ-020 The block SHALL exit BURST to IDLE on the edge after either (a) winc with cnt == MAX_BURST-1, or (b) req[owner] == 0. On exit it SHALL clear gnt, set last = owner and clear cnt.
REQ-021 wfull high during BURST SHALL stall: no winc, cnt held, grant held, with no timeout.
REQ-022 If req[owner] drops while wfull is high, the block SHALL exit per REQ-020(b) with no write.
REQ-023 The request-to-first-write latency SHALL be 1 cycle: req seen at edge t, gnt and first possible winc in cycle t+1.
REQ-024 Every grant change SHALL be separated by exactly one IDLE cycle, during which winc = 0.
REQ-025 req changes of non-owners during BURST SHALL have no effect until the next IDLE cycle.
REQ-026 gnt SHALL never have more than one bit set, and winc SHALL never be high while gnt == 0.

Reset
REQ-027 While wrst is high at a rising edge, the next state SHALL be IDLE, with gnt = 0, cnt = 0 and last = NREQ-1, so that requester 0 has first priority.
REQ-028 While wrst is high, winc SHALL be 0 combinationally, including during a BURST that is interrupted mid-operation; no partial burst resumes after reset.
REQ-029 busy and wdata SHALL read 0 after the reset edge.

Verification
REQ-030 Reset, then req=4'b0001 held, wfull=0 -> gnt=0001 one cycle later; winc high for exactly 4 cycles with lane0 data; then one IDLE cycle; then a new grant to requester 0.
REQ-031 req=4'b1111 held, wfull=0 -> grant order 0,1,2,3,0; 4 writes each; exactly one winc=0 cycle between bursts.
REQ-032 Requester 2 granted, wfull raised after 2 writes for 5 cycles -> winc=0 and gnt held for those 5 cycles; the remaining 2 writes follow; total 4.
REQ-033 Requester 1 granted, req[1] dropped after 1 write -> exit to IDLE; last=1; with req=4'b0011 pending, the next grant goes to 0 (wrap from 1: search 2,3,0).
REQ-034 wrst asserted mid-burst after 2 writes -> winc=0 in that cycle; gnt=0 after the edge; with req=4'b1000 held, the next grant goes to 3 and runs a full 4-word burst.
REQ-035 Random req/wfull for 10k cycles -> gnt always one-hot or zero, winc implies !wfull, each burst <= MAX_BURST, and no requester is starved beyond NREQ grants.
